// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave port among NM
// masters. Ownership is granted per bus cycle (CYC) and held until the owner
// drops CYC; a new owner is granted only after one idle cycle.
// Optional watchdog: define WBRR_TIMEOUT_EN to abort a cycle whose slave
// stops answering for TIMEOUT cycles.
module wb_rr_arbiter #(
   parameter int NM      = 2,
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   // upstream masters
   input  logic [NM-1:0]          i_cyc,
   input  logic [NM-1:0]          i_stb,
   input  logic [NM-1:0]          i_we,
   input  logic [NM*AW-1:0]       i_adr,
   input  logic [NM*DW-1:0]       i_dat,
   input  logic [NM*(DW/8)-1:0]   i_sel,
   output logic [NM-1:0]          o_stall,
   output logic [NM-1:0]          o_ack,
   output logic [NM-1:0]          o_err,
   // downstream slave
   output logic                   o_cyc,
   output logic                   o_stb,
   output logic                   o_we,
   output logic [AW-1:0]          o_adr,
   output logic [DW-1:0]          o_dat,
   output logic [DW/8-1:0]        o_sel,
   input  logic                   i_stall,
   input  logic                   i_ack,
   input  logic                   i_err
);

   localparam int GW = $clog2(NM);
   localparam int OW = $clog2(TIMEOUT) + 1;
   localparam int SW = DW / 8;

   logic          r_owned;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last;
   logic [OW-1:0] r_outstanding;
   logic          r_abort;

   logic          owner_cyc;
   logic          active;
   logic          resp;
   logic          timeout_hit;
   logic [31:0]   grant_ix;
   logic [GW-1:0] winner;
   logic          found;
   logic          cnt_inc;
   logic          cnt_dec;
   logic [OW-1:0] cnt_next;

   assign grant_ix  = 32'(r_grant);
   assign owner_cyc = i_cyc[r_grant];
   assign active    = r_owned && !r_abort;
   assign resp      = i_ack || i_err;

   // Round-robin search: first requester above the previous owner, else the lowest requester.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      winner = r_last;
      found  = 1'b0;
      for (int m = 0; m < NM; m++) begin
         if (!found && i_cyc[m] && (m > int'(r_last))) begin
            winner = GW'(m);
            found  = 1'b1;
         end
      end
      for (int m = 0; m < NM; m++) begin
         if (!found && i_cyc[m]) begin
            winner = GW'(m);
            found  = 1'b1;
         end
      end
   end

   // Next value of the outstanding-request counter; saturates instead of wrapping.
   always_comb begin
      cnt_inc  = o_stb && !i_stall && (r_outstanding != '1);
      cnt_dec  = resp && (r_outstanding != '0);
      cnt_next = r_outstanding;
      if (cnt_inc && !cnt_dec)
         cnt_next = r_outstanding + OW'(1);
      else if (cnt_dec && !cnt_inc)
         cnt_next = r_outstanding - OW'(1);
   end

   // Ownership and outstanding-count state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_reset) begin
         r_owned       <= 1'b0;
         r_grant       <= '0;
         r_last        <= GW'(NM - 1);
         r_outstanding <= '0;
      end else if (!r_owned) begin
         r_outstanding <= '0;
         if (|i_cyc) begin
            r_owned <= 1'b1;
            r_grant <= winner;
         end
      end else if (!owner_cyc) begin
         // Owner released (or aborted) the cycle; late responses are dropped from here on.
         r_owned       <= 1'b0;
         r_last        <= r_grant;
         r_outstanding <= '0;
      end else if (timeout_hit) begin
         r_outstanding <= '0;
      end else if (!r_abort) begin
         r_outstanding <= cnt_next;
      end
   end

`ifdef WBRR_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT);

   logic [WW-1:0] r_wait;

   assign timeout_hit = active && owner_cyc && (r_outstanding != '0) && !resp &&
                        (r_wait == WW'(TIMEOUT - 1));

   // Watchdog: count silent cycles while requests are pending, abort the cycle on expiry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_abort <= 1'b0;
         r_wait  <= '0;
      end else begin
         if (!r_owned || !owner_cyc)
            r_abort <= 1'b0;
         else if (timeout_hit)
            r_abort <= 1'b1;

         if (active && owner_cyc && (r_outstanding != '0) && !resp &&
             (r_wait != WW'(TIMEOUT - 1)))
            r_wait <= r_wait + WW'(1);
         else
            r_wait <= '0;
      end
   end
`else
   assign r_abort     = 1'b0;
   assign timeout_hit = 1'b0;
`endif

   // Downstream mux from the owner and response steering back to it.
   always_comb begin
      o_cyc   = 1'b0;
      o_stb   = 1'b0;
      o_we    = 1'b0;
      o_adr   = '0;
      o_dat   = '0;
      o_sel   = '0;
      o_stall = '1;
      o_ack   = '0;
      o_err   = '0;
      if (active) begin
         o_cyc            = owner_cyc;
         o_stb            = i_stb[r_grant];
         o_we             = i_we[r_grant];
         o_adr            = i_adr[grant_ix*AW +: AW];
         o_dat            = i_dat[grant_ix*DW +: DW];
         o_sel            = i_sel[grant_ix*SW +: SW];
         o_stall[r_grant] = i_stall;
         o_ack[r_grant]   = i_ack;
         o_err[r_grant]   = i_err || timeout_hit;
      end
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone (pipelined) bus arbiter that shares one downstream slave port among NM upstream masters. It sits between bus converters, such as the AXI-lite read and write bridges or a DMA engine, and a single Wishbone interconnect port. Ownership is granted per bus cycle (CYC) and held until the owner drops CYC. An optional per-transaction watchdog aborts hung cycles.

## Interface
- NM, 2: number of upstream masters, 2..8.
- AW, 26: word address width.
- DW, 32: data width; SEL width is DW/8.
- TIMEOUT, 64: watchdog limit in cycles, ≥2. Used only with WBRR_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_cyc  in  NM  per-master CYC, bit m = master m
- i_stb  in  NM  per-master STB
- i_we  in  NM  per-master WE
- i_adr  in  NM*AW  packed addresses, master m at [m*AW +: AW]
- i_dat  in  NM*DW  packed write data
- i_sel  in  NM*DW/8  packed byte selects
- o_stall  out  NM  per-master stall
- o_ack  out  NM  per-master ack
- o_err  out  NM  per-master err
- o_cyc, o_stb, o_we  out  1  downstream control
- o_adr  out  AW  downstream address
- o_dat  out  DW  downstream write data
- o_sel  out  DW/8  downstream byte selects
- i_stall, i_ack, i_err  in  1  downstream responses. Read data goes straight to every master outside this block.

## Operation
- Registered state:
  - r_owned (1b): a master currently owns the bus.
  - r_grant ($clog2(NM)b): index of the owner.
  - r_last ($clog2(NM)b): index of the previous owner.
  - r_outstanding ($clog2(TIMEOUT)+1b): number of accepted, unanswered requests.
- States:
  - IDLE: !r_owned.
  - OWNED: r_owned and not aborted.
  - ABORT: r_owned and r_abort, present only with the macro.
- IDLE → OWNED:
  - Triggered when any i_cyc bit is set.
  - The winner is the first set bit found searching upward from r_last+1, wrapping modulo NM.
  - r_grant takes the winner's index and r_owned is set.
- OWNED → IDLE when i_cyc[r_grant]=0. At that edge r_last ← r_grant, r_owned ← 0 and r_outstanding ← 0.
- Outputs in OWNED:
  - o_cyc = i_cyc[r_grant], o_stb = i_stb[r_grant].
  - o_we, o_adr, o_dat and o_sel are muxed from master r_grant.
  - o_stall[r_grant] = i_stall, o_ack[r_grant] = i_ack, o_err[r_grant] = i_err.
  - Every non-owner sees stall=1, ack=0, err=0.
- Outputs in IDLE:
  - o_cyc, o_stb, o_we, o_adr, o_dat and o_sel are all 0.
  - o_stall = all ones, o_ack = 0, o_err = 0.
- Outstanding counter, both events may occur in the same cycle:
  - +1 on o_stb && !i_stall.
  - -1 on i_ack || i_err.
  - The counter never underflows; a response arriving with zero outstanding is still forwarded.
- Owner drops CYC with requests outstanding: this is an abort. Late i_ack/i_err are dropped because no master is selected.

## Timing
- Reset values:
  - r_owned=0, r_last=NM-1, so master 0 wins first.
  - r_outstanding=0, r_abort=0.
  - All outputs take their IDLE values.
- Grant latency: a request that rises in an idle cycle appears on o_cyc/o_stb on the following cycle. It needs one registered edge.
- Handover: after the owner's CYC falls, o_cyc stays low for at least one cycle before the next owner is granted. Back-to-back owners are therefore separated by exactly one idle cycle.
- Data-path outputs are combinational from the owner's inputs; the arbiter adds zero pipeline latency once a master is granted.
- Reset asserted mid-cycle: all state clears immediately and o_cyc drops asynchronously.

## Configuration
- WBRR_TIMEOUT_EN defined:
  - A wait counter increments each cycle while r_outstanding>0 and neither i_ack nor i_err is set. It clears otherwise.
  - When the wait counter reaches TIMEOUT-1, the arbiter pulses o_err[r_grant] for one cycle, clears r_outstanding, and sets r_abort.
  - In ABORT:
    - o_cyc=0, o_stb=0.
    - Owner stall=1.
    - i_ack and i_err are ignored.
  - ABORT exits to IDLE when the owner drops CYC.
- WBRR_TIMEOUT_EN undefined: no watchdog logic is built and no ABORT state exists. A hung slave holds the bus indefinitely.

## Test plan
- Reset, then i_cyc=2'b11 held → master 0 is granted one cycle later and o_stall=2'b10. After master 0 drops CYC, o_cyc is low for 1 cycle, then master 1 is granted.
- Master 1 only, 4 pipelined writes with i_stall high on the 2nd beat, acks returned 2 cycles later → exactly 4 o_ack[1] pulses, o_ack[0]=0 throughout, and o_adr/o_dat match master 1's values.
- Fairness: both masters re-request immediately after every release, over 10 cycles of bus ownership → grant order is 0,1,0,1,…; neither master wins twice in a row.
- Slave returns i_err on the 2nd of 3 reads → o_err[owner] pulses once, and the 3rd ack is still forwarded.
- Owner drops CYC with 2 requests outstanding, then 2 acks arrive → no o_ack pulse reaches any master, and the next grant proceeds normally.
- WBRR_TIMEOUT_EN, TIMEOUT=8: one request with no ack ever → o_err[owner] pulses 8 cycles after acceptance, o_cyc goes low, and a late i_ack is ignored. State returns to IDLE when the owner drops CYC.
